// File: rtl/rd_fifo_arb_pkg.sv
// Shared types and helpers for the read-side FIFO burst arbiter.
package rd_fifo_arb_pkg;

    // Arbiter FSM: IDLE selects a channel, BURST drains it.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Ceiling log2, used for the channel index and counter widths.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational masked round-robin pick: the first requesting channel at or
// after rr_ptr_i wins, wrapping to the lowest requester when none is above it.
module rr_arbiter
    import rd_fifo_arb_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CH_W-1:0] rr_ptr_i,
    output logic [CH_W-1:0] grant_idx_o,
    output logic            any_req_o
);

    logic [CH_W-1:0] hi_idx;
    logic            hi_found;
    logic [CH_W-1:0] lo_idx;

    // Scan downwards so the final assignment is the lowest qualifying index.
    always_comb begin
        hi_idx   = '0;
        hi_found = 1'b0;
        lo_idx   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_i[i] && (CH_W'(i) >= rr_ptr_i)) begin
                hi_idx   = CH_W'(i);
                hi_found = 1'b1;
            end
            if (req_i[i]) begin
                lo_idx = CH_W'(i);
            end
        end
        any_req_o   = |req_i;
        grant_idx_o = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/rd_fifo_burst_arbiter.sv
// Read-side burst arbiter: shares one consumer between N show-ahead FIFOs,
// granting round-robin and draining up to BURST_LEN beats per grant. A burst
// is cut short when the granted FIFO stays empty for TIMEOUT cycles.
//
// Handshake: a beat transfers on a cycle where out_vld and out_rdy are both
// high; out_vld never depends on out_rdy, and the pop strobe fifo_rd_en of the
// granted channel is exactly that beat condition.
module rd_fifo_burst_arbiter
    import rd_fifo_arb_pkg::*;
#(
    parameter  int N_CH      = 4,
    parameter  int DATA_W    = 32,
    parameter  int BURST_LEN = 16,
    parameter  int TIMEOUT   = 8,
    localparam int CH_W      = clog2(N_CH)
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst,
    input  logic [N_CH-1:0]          ch_en,
    input  logic [N_CH*DATA_W-1:0]   fifo_rd_data,
    input  logic [N_CH-1:0]          fifo_rd_vld,
    output logic [N_CH-1:0]          fifo_rd_en,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_last,
    output logic [CH_W-1:0]          out_ch,
    output logic                     burst_trunc,
    output logic                     busy,
    output arb_state_e               dbg_state
);

    localparam int BEAT_W  = clog2(BURST_LEN + 1);
    localparam int STALL_W = clog2(TIMEOUT + 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]    CH_MAX     = CH_W'(N_CH - 1);

    arb_state_e          state_q, state_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic                trunc_q, trunc_d;

    logic [N_CH-1:0]     req;
    logic [CH_W-1:0]     pick_idx;
    logic                any_req;
    logic [DATA_W-1:0]   head_data;
    logic                head_vld;
    logic                beat;
    logic [CH_W-1:0]     next_ptr;

    assign req = fifo_rd_vld & ch_en;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_rr_arbiter (
        .req_i       (req),
        .rr_ptr_i    (rr_ptr_q),
        .grant_idx_o (pick_idx),
        .any_req_o   (any_req)
    );

    // Head word and valid of the currently granted FIFO.
    always_comb begin
        head_data = '0;
        head_vld  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (CH_W'(i) == grant_q) begin
                head_data = fifo_rd_data[i*DATA_W +: DATA_W];
                head_vld  = fifo_rd_vld[i];
            end
        end
    end

    // Pointer for the next arbitration round: one past the current grant.
    assign next_ptr = (grant_q == CH_MAX) ? '0 : grant_q + CH_W'(1);

    // Next-state, counters and datapath outputs.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        trunc_d     = 1'b0;
        beat        = 1'b0;
        fifo_rd_en  = '0;
        out_data    = '0;
        out_vld     = 1'b0;
        out_last    = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d     = pick_idx;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                    state_d     = BURST;
                end
            end

            BURST: begin
                out_data = head_data;
                out_vld  = head_vld;
                beat     = head_vld & out_rdy;
                for (int i = 0; i < N_CH; i++) begin
                    fifo_rd_en[i] = beat && (CH_W'(i) == grant_q);
                end
                out_last = beat && (beat_cnt_q == BEAT_LAST);

                if (beat) begin
                    if (beat_cnt_q == BEAT_LAST) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end

                // Only an empty head counts as starvation; backpressure does not.
                if (head_vld) begin
                    stall_cnt_d = '0;
                end else if (stall_cnt_q == STALL_LAST) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                    trunc_d  = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
            trunc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            trunc_q     <= trunc_d;
        end
    end

    assign out_ch      = grant_q;
    assign burst_trunc = trunc_q;
    assign busy        = (state_q == BURST);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rd_fifo_burst_arbiter.sv
// Directed bench for rd_fifo_burst_arbiter with behavioural show-ahead FIFOs.
module tb_rd_fifo_burst_arbiter;
    import rd_fifo_arb_pkg::*;

    localparam int N_CH      = 4;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 16;
    localparam int TIMEOUT   = 8;
    localparam int CH_W      = clog2(N_CH);

    logic                    rd_clk;
    logic                    rd_rst;
    logic [N_CH-1:0]         ch_en;
    logic [N_CH*DATA_W-1:0]  fifo_rd_data;
    logic [N_CH-1:0]         fifo_rd_vld;
    logic [N_CH-1:0]         fifo_rd_en;
    logic [DATA_W-1:0]       out_data;
    logic                    out_vld;
    logic                    out_rdy;
    logic                    out_last;
    logic [CH_W-1:0]         out_ch;
    logic                    burst_trunc;
    logic                    busy;
    arb_state_e              dbg_state;

    rd_fifo_burst_arbiter #(
        .N_CH      (N_CH),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .ch_en        (ch_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_en   (fifo_rd_en),
        .out_data     (out_data),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_last     (out_last),
        .out_ch       (out_ch),
        .burst_trunc  (burst_trunc),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // ---------------- FIFO model ----------------
    // pushed counts words made available; popped counts words consumed.
    int pushed [N_CH];
    int popped [N_CH];

    initial begin
        for (int i = 0; i < N_CH; i++) begin
            pushed[i] = 0;
            popped[i] = 0;
        end
    end

    always @(posedge rd_clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (fifo_rd_en[i]) popped[i] <= popped[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            fifo_rd_vld[i] = (pushed[i] != popped[i]);
            fifo_rd_data[i*DATA_W +: DATA_W] = {8'(i + 1), 24'(popped[i])};
        end
    end

    // ---------------- scoreboard state ----------------
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int push_cyc;
    int n_nrdy_pop;
    int rdy_idx;
    logic rdy_pat [4];

    logic [DATA_W-1:0] exp_q [$];
    logic [CH_W-1:0]   beat_ch_q [$];
    logic              beat_last_q [$];
    int                beat_cyc_q [$];
    int                trunc_cyc_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        exp_q.delete();
        beat_ch_q.delete();
        beat_last_q.delete();
        beat_cyc_q.delete();
        trunc_cyc_q.delete();
        n_nrdy_pop = 0;
        rdy_idx    = 0;
        for (int i = 0; i < 4; i++) rdy_pat[i] = 1'b1;
    endtask

    // One clock cycle: drive out_rdy after the falling edge, then sample.
    task automatic tick();
        logic [N_CH-1:0] exp_en;
        logic            bt;
        @(negedge rd_clk);
        out_rdy = rdy_pat[rdy_idx % 4];
        rdy_idx++;
        #1;
        cyc++;
        bt     = out_vld && out_rdy;
        exp_en = '0;
        if (busy && out_rdy && fifo_rd_vld[out_ch]) exp_en[out_ch] = 1'b1;
        chk("rd_en", fifo_rd_en, exp_en);
        chk("last_gate", out_last & ~bt, 0);
        if (!out_rdy && (fifo_rd_en != '0)) n_nrdy_pop++;
        if (bt) begin
            exp_q.push_back({8'(out_ch) + 8'd1, 24'(popped[out_ch])});
            beat_ch_q.push_back(out_ch);
            beat_last_q.push_back(out_last);
            beat_cyc_q.push_back(cyc);
            chk("beat_data", out_data, exp_q.pop_front());
        end
        if (burst_trunc) trunc_cyc_q.push_back(cyc);
    endtask

    task automatic run_until_beats(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (beat_ch_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, beat_ch_q.size(), n);
    endtask

    task automatic reset_dut();
        rd_rst = 1'b1;
        repeat (2) @(negedge rd_clk);
        for (int i = 0; i < N_CH; i++) pushed[i] = popped[i];
        ch_en  = '1;
        out_rdy = 1'b1;
        @(negedge rd_clk);
        rd_rst = 1'b0;
        clear_logs();
    endtask

    function automatic int count_last(input int lo, input int hi);
        int c;
        c = 0;
        for (int i = lo; i <= hi; i++) if (beat_last_q[i]) c++;
        return c;
    endfunction

    function automatic int count_ch_not(input int lo, input int hi, input logic [CH_W-1:0] ch);
        int c;
        c = 0;
        for (int i = lo; i <= hi; i++) if (beat_ch_q[i] != ch) c++;
        return c;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int snap;
        logic [CH_W-1:0] rr_order [5];
        rr_order[0] = 0; rr_order[1] = 1; rr_order[2] = 2; rr_order[3] = 3; rr_order[4] = 0;

        rd_rst  = 1'b1;
        ch_en   = '1;
        out_rdy = 1'b1;
        clear_logs();
        repeat (3) @(negedge rd_clk);
        #1;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_vld", out_vld, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_trunc", burst_trunc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, IDLE);
        @(negedge rd_clk);
        rd_rst = 1'b0;

        // Round-robin across four full channels: 0,1,2,3,0.
        for (int i = 0; i < N_CH; i++) pushed[i] = pushed[i] + 100;
        push_cyc = cyc;
        run_until_beats("rr_beats", 80, 500);
        chk("rr_latency", beat_cyc_q[0] - push_cyc, 1);
        for (int b = 0; b < 5; b++) begin
            chk("rr_grant", beat_ch_q[b*16], rr_order[b]);
            chk("rr_same_ch", count_ch_not(b*16, b*16 + 15, rr_order[b]), 0);
            chk("rr_last", beat_last_q[b*16 + 15], 1);
        end
        chk("rr_last_count", count_last(0, 79), 5);
        chk("rr_bubble", beat_cyc_q[16] - beat_cyc_q[15], 2);

        // Asynchronous reset in the middle of the next burst.
        repeat (4) tick();
        chk("mid_busy", busy, 1);
        snap = popped[0] + popped[1] + popped[2] + popped[3];
        #1 rd_rst = 1'b1;
        #1;
        chk("arst_rd_en", fifo_rd_en, 0);
        chk("arst_vld", out_vld, 0);
        chk("arst_last", out_last, 0);
        chk("arst_ch", out_ch, 0);
        chk("arst_trunc", burst_trunc, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data", out_data, 0);
        @(posedge rd_clk);
        #1;
        chk("arst_no_pop", popped[0] + popped[1] + popped[2] + popped[3], snap);
        reset_dut();

        // Single channel with 40 words: 16, 16, then 8 and a truncation.
        pushed[2] = pushed[2] + 40;
        push_cyc = cyc;
        run_until_beats("sc_beats", 40, 300);
        repeat (TIMEOUT + 4) tick();
        chk("sc_latency", beat_cyc_q[0] - push_cyc, 1);
        chk("sc_channel", count_ch_not(0, 39, 2), 0);
        chk("sc_last15", beat_last_q[15], 1);
        chk("sc_last31", beat_last_q[31], 1);
        chk("sc_last_count", count_last(0, 39), 2);
        chk("sc_contig", beat_cyc_q[15] - beat_cyc_q[0], 15);
        chk("sc_bubble1", beat_cyc_q[16] - beat_cyc_q[15], 2);
        chk("sc_bubble2", beat_cyc_q[32] - beat_cyc_q[31], 2);
        chk("sc_trunc_n", trunc_cyc_q.size(), 1);
        chk("sc_trunc_t", trunc_cyc_q[0] - beat_cyc_q[39], TIMEOUT + 1);
        chk("sc_idle", busy, 0);
        reset_dut();

        // Backpressure: out_rdy follows 1,0,0,1 for a 16-word burst.
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
        snap = popped[0];
        pushed[0] = pushed[0] + 16;
        run_until_beats("bp_beats", 16, 200);
        repeat (20) tick();
        chk("bp_pops", popped[0] - snap, 16);
        chk("bp_nrdy_pop", n_nrdy_pop, 0);
        chk("bp_trunc", trunc_cyc_q.size(), 0);
        chk("bp_last15", beat_last_q[15], 1);
        chk("bp_last_count", count_last(0, 15), 1);
        reset_dut();

        // Starvation: ch1 supplies 5 words while ch3 waits.
        pushed[1] = pushed[1] + 5;
        pushed[3] = pushed[3] + 20;
        run_until_beats("st_beats", 21, 300);
        chk("st_ch_first", count_ch_not(0, 4, 1), 0);
        chk("st_trunc_t", trunc_cyc_q[0] - beat_cyc_q[4], TIMEOUT + 1);
        chk("st_next_ch", beat_ch_q[5], 3);
        chk("st_next_t", beat_cyc_q[5] - trunc_cyc_q[0], 1);
        chk("st_no_last", count_last(0, 4), 0);
        chk("st_ch3_last", beat_last_q[20], 1);
        reset_dut();

        // Channel mask 1010, then ch1 disabled during its second burst.
        ch_en = 4'b1010;
        for (int i = 0; i < N_CH; i++) pushed[i] = pushed[i] + 100;
        run_until_beats("mk_beats_a", 40, 300);
        ch_en = 4'b1000;
        run_until_beats("mk_beats_b", 64, 300);
        chk("mk_b0", beat_ch_q[0], 1);
        chk("mk_b1", beat_ch_q[16], 3);
        chk("mk_b2", beat_ch_q[32], 1);
        chk("mk_b2_whole", count_ch_not(32, 47, 1), 0);
        chk("mk_b2_last", beat_last_q[47], 1);
        chk("mk_b3", count_ch_not(48, 63, 3), 0);
        chk("mk_masked", count_ch_not(0, 63, 1) - count_ch_not(0, 63, 0)
                         + count_ch_not(0, 63, 2) - count_ch_not(0, 63, 3) + 64, 64);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
